// File: rtl/dp_ram_fifo_pkg.sv
// Shared widths, types and helpers for the dual-port-RAM FIFO controller.
// Depth is fixed at 2**AW so the address pointers wrap by plain overflow.
package dp_ram_fifo_pkg;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   typedef logic [DW-1:0] data_t;
   typedef logic [AW-1:0] addr_t;
   typedef logic [AW+1:0] lvl_t;
   typedef logic [AW:0]   cnt_t;

   localparam cnt_t  DEPTH_CNT = cnt_t'(DEPTH);
   localparam cnt_t  CNT_ZERO  = {(AW+1){1'b0}};
   localparam cnt_t  CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam addr_t ADDR_ZERO = {AW{1'b0}};
   localparam addr_t ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam data_t DATA_ZERO = {DW{1'b0}};
   localparam lvl_t  LVL_ZERO  = {(AW+2){1'b0}};

   function automatic lvl_t calc_level(input cnt_t ram_count, input logic pend,
                                       input logic [1:0] ob_count);
      return lvl_t'(ram_count) + lvl_t'(pend) + lvl_t'(ob_count);
   endfunction

endpackage

// File: rtl/dp_ram_fifo_obuf.sv
// Two-entry prefetch buffer that catches RAM read data; entry 0 is the head.
// A load in the same cycle as a pop lands in the first slot left free after the pop.
module dp_ram_fifo_obuf
   import dp_ram_fifo_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  data_t      i_load_data,
   input  logic       i_pop,
   output logic [1:0] o_count,
   output data_t      o_head
);

   data_t      r_ob0;
   data_t      r_ob1;
   logic [1:0] r_count;

   // Buffer storage and occupancy update
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ob0   <= DATA_ZERO;
         r_ob1   <= DATA_ZERO;
         r_count <= 2'd0;
      end else begin
         case ({i_pop, i_load})
            2'b10: begin
               r_ob0   <= r_ob1;
               r_count <= r_count - 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd0) begin
                  r_ob0 <= i_load_data;
               end else begin
                  r_ob1 <= i_load_data;
               end
               r_count <= r_count + 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_ob0 <= i_load_data;
               end else begin
                  r_ob0 <= r_ob1;
                  r_ob1 <= i_load_data;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_ob0;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving an external 1-cycle-latency dual-port RAM, with a
// 2-entry prefetch buffer so one word per cycle can flow in and out.
module dp_ram_fifo_ctrl
   import dp_ram_fifo_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_in_valid,
   output logic  o_in_ready,
   input  data_t i_in_data,
   output logic  o_out_valid,
   input  logic  i_out_ready,
   output data_t o_out_data,
   output lvl_t  o_level,
   output logic  o_ram_write_en,
   output addr_t o_ram_write_addr,
   output data_t o_ram_d_in,
   output logic  o_ram_read_en,
   output addr_t o_ram_read_addr,
   input  data_t i_ram_d_out
);

   addr_t      r_wr_ptr;
   addr_t      r_rd_ptr;
   cnt_t       r_ram_count;
   logic       r_rd_pending;
   logic       w_push;
   logic       w_pop;
   logic       w_issue;
   logic [1:0] w_ob_count;
   data_t      w_ob_head;
   logic [2:0] w_slots;

   assign o_in_ready  = !i_rst && (r_ram_count < DEPTH_CNT);
   assign w_push      = i_in_valid && o_in_ready;
   assign o_out_valid = !i_rst && (w_ob_count != 2'd0);
   assign w_pop       = o_out_valid && i_out_ready;

   // Slots the buffer will hold once in-flight data lands and this cycle's pop leaves
   assign w_slots = {1'b0, w_ob_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
   assign w_issue = !i_rst && (r_ram_count != CNT_ZERO) && (w_slots < 3'd2);

   assign o_ram_write_en   = w_push;
   assign o_ram_write_addr = i_rst ? ADDR_ZERO : r_wr_ptr;
   assign o_ram_d_in       = i_rst ? DATA_ZERO : i_in_data;
   assign o_ram_read_en    = w_issue;
   assign o_ram_read_addr  = i_rst ? ADDR_ZERO : r_rd_ptr;
   assign o_out_data       = i_rst ? DATA_ZERO : w_ob_head;
   assign o_level          = i_rst ? LVL_ZERO : calc_level(r_ram_count, r_rd_pending, w_ob_count);

   // Pointers, RAM occupancy and read-in-flight tracking
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr     <= ADDR_ZERO;
         r_rd_ptr     <= ADDR_ZERO;
         r_ram_count  <= CNT_ZERO;
         r_rd_pending <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_ONE;
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + ADDR_ONE;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_push, w_issue})
            2'b10:   r_ram_count <= r_ram_count + CNT_ONE;
            2'b01:   r_ram_count <= r_ram_count - CNT_ONE;
            default: r_ram_count <= r_ram_count;
         endcase
         r_rd_pending <= w_issue;
      end
   end

   dp_ram_fifo_obuf u_obuf (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (r_rd_pending),
      .i_load_data (i_ram_d_out),
      .i_pop       (w_pop),
      .o_count     (w_ob_count),
      .o_head      (w_ob_head)
   );

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Scoreboard bench for dp_ram_fifo_ctrl with a behavioural 1-cycle-latency RAM.
module tb_dp_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [9:0] level;
   logic       ram_write_en;
   logic [7:0] ram_write_addr;
   logic [7:0] ram_d_in;
   logic       ram_read_en;
   logic [7:0] ram_read_addr;
   logic [7:0] ram_d_out;
   logic [7:0] mem [0:255];

   int         n_checks = 0;
   int         n_pass = 0;
   int         n_out = 0;
   int         max_level = 0;
   int         collisions = 0;
   logic [7:0] sb_q [$];
   logic       hold_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;

   always #5 clk = ~clk;

   dp_ram_fifo_ctrl dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_in_valid       (in_valid),
      .o_in_ready       (in_ready),
      .i_in_data        (in_data),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_out_data       (out_data),
      .o_level          (level),
      .o_ram_write_en   (ram_write_en),
      .o_ram_write_addr (ram_write_addr),
      .o_ram_d_in       (ram_d_in),
      .o_ram_read_en    (ram_read_en),
      .o_ram_read_addr  (ram_read_addr),
      .i_ram_d_out      (ram_d_out)
   );

   always @(posedge clk) begin
      if (ram_write_en) mem[ram_write_addr] <= ram_d_in;
      if (ram_read_en) ram_d_out <= mem[ram_read_addr];
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) sb_q.push_back(in_data);
         if (hold_prev) begin
            check_eq("hold_data", out_data, data_prev);
            check_eq("hold_valid", out_valid, 1);
         end
         if (out_valid && out_ready) begin
            n_out++;
            check_eq("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) check_eq("sb_data", out_data, sb_q.pop_front());
         end
         if (int'(level) > max_level) max_level = int'(level);
         if (ram_write_en && ram_read_en && ram_write_addr == ram_read_addr) collisions++;
         hold_prev = out_valid && !out_ready;
         data_prev = out_data;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic drain(input string tag);
      tick;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 600 && (sb_q.size() != 0 || out_valid); k++) tick;
      @(negedge clk);
      check_eq({tag, "_q_empty"}, sb_q.size(), 0);
      check_eq({tag, "_out_valid"}, out_valid, 0);
      check_eq({tag, "_level"}, level, 0);
   endtask

   initial begin
      int start;
      int stalls;
      int pushed;

      rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
      tick; tick;
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_wr_en", ram_write_en, 0);
      check_eq("rst_rd_en", ram_read_en, 0);
      check_eq("rst_wr_addr", ram_write_addr, 0);
      check_eq("rst_rd_addr", ram_read_addr, 0);
      check_eq("rst_d_in", ram_d_in, 0);

      // single word latency
      tick; rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
      @(negedge clk);
      check_eq("c0_in_ready", in_ready, 1);
      check_eq("c0_wr_en", ram_write_en, 1);
      check_eq("c0_wr_addr", ram_write_addr, 0);
      check_eq("c0_d_in", ram_d_in, 8'hA5);
      check_eq("c0_rd_en", ram_read_en, 0);
      tick; in_valid = 1'b0;
      @(negedge clk);
      check_eq("c1_rd_en", ram_read_en, 1);
      check_eq("c1_rd_addr", ram_read_addr, 0);
      check_eq("c1_level", level, 1);
      check_eq("c1_out_valid", out_valid, 0);
      tick;
      @(negedge clk);
      check_eq("c2_out_valid", out_valid, 0);
      check_eq("c2_level", level, 1);
      tick;
      @(negedge clk);
      check_eq("c3_out_valid", out_valid, 1);
      check_eq("c3_out_data", out_data, 8'hA5);
      check_eq("c3_level", level, 1);
      tick;
      @(negedge clk);
      check_eq("c4_out_data", out_data, 8'hA5);
      tick; out_ready = 1'b1;
      tick;
      @(negedge clk);
      check_eq("c6_out_valid", out_valid, 0);
      check_eq("c6_level", level, 0);

      // continuous stream, crosses the pointer wrap
      start = n_out;
      stalls = 0;
      for (int i = 0; i < 300; i++) begin
         tick; in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
         @(negedge clk);
         if (!in_ready) stalls++;
      end
      tick; in_valid = 1'b0;
      check_eq("stream_stalls", stalls, 0);
      check_eq("stream_rate", n_out - start, 297);
      drain("stream");
      check_eq("stream_total", n_out - start, 300);

      // fill to maximum level
      tick; out_ready = 1'b0;
      stalls = 0;
      for (int i = 0; i < 258; i++) begin
         tick; in_valid = 1'b1; in_data = 8'(i) ^ 8'h5A;
         @(negedge clk);
         if (!in_ready) stalls++;
      end
      check_eq("full_stalls", stalls, 0);
      tick; in_valid = 1'b1; in_data = 8'hEE;
      @(negedge clk);
      check_eq("full_in_ready", in_ready, 0);
      check_eq("full_level", level, 258);
      tick; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_eq("full_pop_rd_en", ram_read_en, 1);
      check_eq("full_pop_in_ready", in_ready, 0);
      tick; out_ready = 1'b0;
      @(negedge clk);
      check_eq("full_after_in_ready", in_ready, 1);
      check_eq("full_after_level", level, 257);
      drain("full");

      // random traffic
      pushed = 0;
      for (int c = 0; c < 60000 && pushed < 10000; c++) begin
         tick;
         in_valid  = ($urandom_range(0, 1) == 1);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (in_valid && in_ready) pushed++;
      end
      tick; in_valid = 1'b0;
      check_eq("rand_pushed", pushed, 10000);
      drain("rand");
      check_eq("max_level_ok", max_level <= 258, 1);
      check_eq("max_level_reached", max_level, 258);
      check_eq("addr_collisions", collisions, 0);

      // reset with a read in flight
      tick; out_ready = 1'b0;
      for (int i = 0; i < 41; i++) begin
         tick; in_valid = 1'b1; in_data = 8'(i + 100);
      end
      tick; in_valid = 1'b0;
      tick; tick; tick;
      @(negedge clk);
      check_eq("pre_rst_level", level, 41);
      tick; out_ready = 1'b1;
      @(negedge clk);
      check_eq("pre_rst_rd_en", ram_read_en, 1);
      tick; out_ready = 1'b0; rst = 1'b1; sb_q.delete();
      @(negedge clk);
      check_eq("mid_rst_level", level, 0);
      check_eq("mid_rst_out_valid", out_valid, 0);
      tick; rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_level", level, 0);
      check_eq("post_rst_out_valid", out_valid, 0);
      check_eq("post_rst_in_ready", in_ready, 1);
      tick; in_valid = 1'b1; in_data = 8'h3C;
      tick; in_data = 8'h3D;
      tick; in_data = 8'h3E;
      tick; in_valid = 1'b0;
      for (int k = 0; k < 10 && !out_valid; k++) tick;
      @(negedge clk);
      check_eq("post_rst_first_valid", out_valid, 1);
      check_eq("post_rst_first_data", out_data, 8'h3C);

      // drain to empty and stay idle
      drain("tail");
      for (int k = 0; k < 3; k++) begin
         tick;
         @(negedge clk);
         check_eq("idle_rd_en", ram_read_en, 0);
         check_eq("idle_out_valid", out_valid, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
